datapath_sequencer: RTL and testbench

DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

---
 rtl/datapath_sequencer_pkg.sv | 25 ++
 rtl/datapath_sequencer_prog_mem.sv | 25 ++
 rtl/datapath_sequencer.sv | 115 +++++++++++
 tb/tb_datapath_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/datapath_sequencer_pkg.sv
// Shared types for the microcoded datapath sequencer:
// control-word layout, program-word layout and FSM encoding.
package datapath_sequencer_pkg;

  typedef struct packed {
    logic       r_en;
    logic       q_en;
    logic [1:0] shift_op;
    logic       mux_sel;
    logic [2:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic       last;
    logic [2:0] rpt;
    ctrl_t      ctrl;
  } prog_word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/datapath_sequencer_prog_mem.sv
// Program store: synchronous write, combinational read.
// Contents are deliberately not touched by reset.
module seq_prog_mem
  import datapath_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  prog_word_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output prog_word_t    rdata_o
);

  prog_word_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/datapath_sequencer.sv
// Sequencer that replays program entries as registered
// datapath control words, each repeated rpt+1 cycles.
module datapath_sequencer
  import datapath_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [11:0]   prog_data,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic          abort,
  output logic [7:0]    ctrl_bus,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc,
  output logic          err
);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [2:0]    rcnt_q, rcnt_d;
  logic          last_q, last_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic          err_q, err_d;
  logic          idle;
  logic          mem_we;
  logic [AW-1:0] rd_addr;
  prog_word_t    rd_word;

  assign idle    = (state_q == ST_IDLE);
  assign mem_we  = prog_we & idle & ~rst;
  assign rd_addr = idle ? start_addr : pc_q + AW'(1);

  seq_prog_mem #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk    (clk),
    .we_i   (mem_we),
    .waddr_i(prog_addr),
    .wdata_i(prog_word_t'(prog_data)),
    .raddr_i(rd_addr),
    .rdata_o(rd_word)
  );

  // Entry fields are latched on load so a same-cycle
  // write cannot alter the entry already being issued.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rcnt_d  = rcnt_q;
    last_d  = last_q;
    ctrl_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = start_addr;
          rcnt_d  = rd_word.rpt;
          last_d  = rd_word.last;
          ctrl_d  = rd_word.ctrl;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_DONE;
        end else if (rcnt_q != 3'd0) begin
          rcnt_d = rcnt_q - 3'd1;
          ctrl_d = ctrl_q;
        end else if (last_q) begin
          state_d = ST_DONE;
        end else begin
          pc_d   = pc_q + AW'(1);
          rcnt_d = rd_word.rpt;
          last_d = rd_word.last;
          ctrl_d = rd_word.ctrl;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign err_d = err_q | (~idle & (start | prog_we));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      rcnt_q  <= '0;
      last_q  <= 1'b0;
      ctrl_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rcnt_q  <= rcnt_d;
      last_q  <= last_d;
      ctrl_q  <= ctrl_d;
      err_q   <= err_d;
    end
  end

  assign ctrl_bus = ctrl_q;
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign pc       = pc_q;
  assign err      = err_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: hand-computed
// control-word sequences, abort, error and reset cases.
module tb_datapath_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [11:0] prog_data;
  logic       start;
  logic [3:0] start_addr;
  logic       abort;
  logic [7:0] ctrl_bus;
  logic       busy;
  logic       done;
  logic [3:0] pc;
  logic       err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  datapath_sequencer #(.DEPTH(16), .AW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .start     (start),
    .start_addr(start_addr),
    .abort     (abort),
    .ctrl_bus  (ctrl_bus),
    .busy      (busy),
    .done      (done),
    .pc        (pc),
    .err       (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] c,
                            input logic b, input logic d,
                            input logic [3:0] p);
    chk({tag, ".ctrl"}, ctrl_bus, c);
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, b});
    chk({tag, ".done"}, {7'd0, done}, {7'd0, d});
    chk({tag, ".pc"}, {4'd0, pc}, {4'd0, p});
  endtask

  task automatic wr(input logic [3:0] a, input logic [11:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic go(input logic [3:0] a);
    start      = 1'b1;
    start_addr = a;
    tick();
    start      = 1'b0;
  endtask

  initial begin
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; start_addr = '0; abort = 1'b0;
    tick();
    tick();
    expect_out("reset", 8'h00, 1'b0, 1'b0, 4'd0);
    chk("reset.err", {7'd0, err}, 8'd0);
    rst = 1'b0;

    // Basic two-entry program
    wr(4'd0, 12'h041);
    wr(4'd1, 12'hA83);
    go(4'd0);
    expect_out("basic.c1", 8'h41, 1'b1, 1'b0, 4'd0);
    tick();
    expect_out("basic.c2", 8'h83, 1'b1, 1'b0, 4'd1);
    tick();
    expect_out("basic.c3", 8'h83, 1'b1, 1'b0, 4'd1);
    tick();
    expect_out("basic.c4", 8'h83, 1'b1, 1'b0, 4'd1);
    tick();
    expect_out("basic.c5", 8'h00, 1'b0, 1'b1, 4'd1);
    tick();
    expect_out("basic.c6", 8'h00, 1'b0, 1'b0, 4'd1);

    // Wrap from last address to 0
    wr(4'd15, 12'h055);
    wr(4'd0, 12'h866);
    go(4'd15);
    expect_out("wrap.c1", 8'h55, 1'b1, 1'b0, 4'd15);
    tick();
    expect_out("wrap.c2", 8'h66, 1'b1, 1'b0, 4'd0);
    tick();
    expect_out("wrap.c3", 8'h00, 1'b0, 1'b1, 4'd0);
    tick();

    // Abort on second cycle of a 4-cycle entry
    wr(4'd2, 12'h3C5);
    wr(4'd3, 12'h8AA);
    go(4'd2);
    expect_out("abort.c1", 8'hC5, 1'b1, 1'b0, 4'd2);
    tick();
    expect_out("abort.c2", 8'hC5, 1'b1, 1'b0, 4'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    expect_out("abort.c3", 8'h00, 1'b0, 1'b1, 4'd2);
    tick();
    expect_out("abort.c4", 8'h00, 1'b0, 1'b0, 4'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    expect_out("abort.idle", 8'h00, 1'b0, 1'b0, 4'd2);
    chk("abort.err", {7'd0, err}, 8'd0);

    // Start and write while busy are rejected
    go(4'd2);
    expect_out("err.c1", 8'hC5, 1'b1, 1'b0, 4'd2);
    start = 1'b1; start_addr = 4'd3;
    prog_we = 1'b1; prog_addr = 4'd2; prog_data = 12'h0FF;
    tick();
    start = 1'b0; prog_we = 1'b0;
    expect_out("err.c2", 8'hC5, 1'b1, 1'b0, 4'd2);
    chk("err.set", {7'd0, err}, 8'd1);
    tick();
    tick();
    expect_out("err.c4", 8'hC5, 1'b1, 1'b0, 4'd2);
    tick();
    expect_out("err.c5", 8'hAA, 1'b1, 1'b0, 4'd3);
    tick();
    expect_out("err.c6", 8'h00, 1'b0, 1'b1, 4'd3);
    tick();
    go(4'd2);
    expect_out("err.rerun", 8'hC5, 1'b1, 1'b0, 4'd2);
    chk("err.held", {7'd0, err}, 8'd1);

    // Reset mid-run, then rerun
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_out("rst.mid", 8'h00, 1'b0, 1'b0, 4'd0);
    chk("rst.err", {7'd0, err}, 8'd0);
    go(4'd2);
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("rerun.c%0d", i + 1), 8'hC5, 1'b1, 1'b0, 4'd2);
      tick();
    end
    expect_out("rerun.c5", 8'hAA, 1'b1, 1'b0, 4'd3);
    tick();
    expect_out("rerun.c6", 8'h00, 1'b0, 1'b1, 4'd3);
    tick();

    // Start and write together: run sees old entry
    start = 1'b1; start_addr = 4'd3;
    prog_we = 1'b1; prog_addr = 4'd3; prog_data = 12'h811;
    tick();
    start = 1'b0; prog_we = 1'b0;
    expect_out("same.c1", 8'hAA, 1'b1, 1'b0, 4'd3);
    chk("same.err", {7'd0, err}, 8'd0);
    tick();
    expect_out("same.c2", 8'h00, 1'b0, 1'b1, 4'd3);
    tick();
    go(4'd3);
    expect_out("same.new", 8'h11, 1'b1, 1'b0, 4'd3);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
